// File: rtl/rx_wb_pack.sv
// Multi-channel I/Q capture, round-robin arbitration into a tagged FIFO, and
// 16-bit word readout sequencing for the host read path.
module rx_wb_pack #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned IN_BITS = 18,
   parameter int unsigned DEPTH   = 16
) (
   input  logic                     adc_clk,
   input  logic                     reset_n,
   input  logic [NCH-1:0]           in_strobe,
   input  logic [NCH*IN_BITS-1:0]   in_i,
   input  logic [NCH*IN_BITS-1:0]   in_q,
   input  logic [NCH-1:0]           ch_en,
   input  logic                     fmt,
   input  logic                     rd_pulse,
   output logic [15:0]              rd_dout,
   output logic                     rd_valid,
   output logic [2:0]               rd_ch,
   output logic                     rd_first,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              ovfl_cnt,
   input  logic                     clr_ovfl
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned EW = 3 + 2 * IN_BITS;

   logic [NCH-1:0]              pend, pend_d, cand, drop;
   logic [NCH-1:0][IN_BITS-1:0] hold_i, hold_i_d, hold_q, hold_q_d;
   logic [2:0]                  rr, win;
   logic [IN_BITS-1:0]          win_i, win_q;
   logic                        wr_en, full, pop;
   logic [EW-1:0]               mem [DEPTH];
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic [EW-1:0]               head;
   logic [IN_BITS-1:0]          head_i, head_q, i_sh, q_sh;
   logic [2:0]                  head_ch;
   logic [1:0]                  w;
   logic                        fmt_q, fmt_eff, last_word;
   logic [3:0]                  drop_n;
   logic [16:0]                 ovfl_sum;
   logic [15:0]                 ovfl_d;

   assign cand  = pend & ch_en;
   assign full  = (level == LW'(DEPTH));
   assign wr_en = (|cand) && !full;

   // Lowest pending index overall, overridden by the lowest one at/after rr.
   always_comb begin
      win   = '0;
      win_i = '0;
      win_q = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (cand[c]) begin
            win   = 3'(c);
            win_i = hold_i[c];
            win_q = hold_q[c];
         end
      end
      for (int c = NCH - 1; c >= 0; c--) begin
         if (cand[c] && (3'(c) >= rr)) begin
            win   = 3'(c);
            win_i = hold_i[c];
            win_q = hold_q[c];
         end
      end
   end

   // A channel being written this cycle may accept a new sample without a drop.
   always_comb begin
      pend_d   = pend;
      hold_i_d = hold_i;
      hold_q_d = hold_q;
      drop     = '0;
      for (int c = 0; c < NCH; c++) begin
         if (!ch_en[c]) begin
            pend_d[c] = 1'b0;
         end else if (in_strobe[c]) begin
            if (!pend[c] || (wr_en && (win == 3'(c)))) begin
               hold_i_d[c] = in_i[c*IN_BITS +: IN_BITS];
               hold_q_d[c] = in_q[c*IN_BITS +: IN_BITS];
               pend_d[c]   = 1'b1;
            end else begin
               drop[c] = 1'b1;
            end
         end else if (wr_en && (win == 3'(c))) begin
            pend_d[c] = 1'b0;
         end
      end
   end

   always_comb begin
      drop_n = '0;
      for (int c = 0; c < NCH; c++) begin
         drop_n = drop_n + 4'(drop[c]);
      end
      ovfl_sum = {1'b0, ovfl_cnt} + 17'(drop_n);
      if (clr_ovfl) begin
         ovfl_d = 16'(drop_n);
      end else if (ovfl_sum[16]) begin
         ovfl_d = 16'hFFFF;
      end else begin
         ovfl_d = ovfl_sum[15:0];
      end
   end

   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         pend     <= '0;
         hold_i   <= '0;
         hold_q   <= '0;
         rr       <= '0;
         ovfl_cnt <= '0;
      end else begin
         pend     <= pend_d;
         hold_i   <= hold_i_d;
         hold_q   <= hold_q_d;
         ovfl_cnt <= ovfl_d;
         if (wr_en) begin
            rr <= (win == 3'(NCH - 1)) ? 3'd0 : win + 3'd1;
         end
      end
   end

   always_ff @(posedge adc_clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {win, win_i, win_q};
      end
   end

   assign head     = mem[rd_ptr];
   assign head_ch  = head[EW-1 -: 3];
   assign head_i   = head[2*IN_BITS-1:IN_BITS];
   assign head_q   = head[IN_BITS-1:0];
   assign i_sh     = $signed(head_i) >>> 16;
   assign q_sh     = $signed(head_q) >>> 16;
   assign rd_valid = (level != '0);
   assign rd_first = (w == 2'd0);

   // Format is latched at word 0 so a mid-sample change cannot split a sample.
   assign fmt_eff   = (w == 2'd0) ? fmt : fmt_q;
   assign last_word = fmt_eff ? (w == 2'd1) : (w == 2'd2);
   assign pop       = rd_pulse && rd_valid && last_word;

   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         w      <= '0;
         fmt_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_en && !pop) begin
            level <= level + LW'(1);
         end else if (!wr_en && pop) begin
            level <= level - LW'(1);
         end
         if (rd_pulse && rd_valid) begin
            w <= last_word ? 2'd0 : w + 2'd1;
            if (w == 2'd0) begin
               fmt_q <= fmt;
            end
         end
      end
   end

   always_comb begin
      rd_dout = '0;
      rd_ch   = '0;
      if (rd_valid) begin
         rd_ch = head_ch;
         if (fmt_eff) begin
            rd_dout = (w == 2'd0) ? head_i[IN_BITS-1 -: 16] : head_q[IN_BITS-1 -: 16];
         end else begin
            case (w)
               2'd0:    rd_dout = head_i[15:0];
               2'd1:    rd_dout = head_q[15:0];
               default: rd_dout = {i_sh[7:0], q_sh[7:0]};
            endcase
         end
      end
   end

endmodule

// File: doc/rx_wb_pack.md
Name: rx_wb_pack

Overview:
Multi-channel sample buffer and readout sequencer for decimated receiver I/Q outputs.
- Accepts per-channel I/Q samples with individual strobes.
- Arbitrates them round-robin into a shared tagged FIFO.
- Serves the FIFO to the host readout path as a fixed sequence of 16-bit words.
- Generalises the single-channel WB/narrowband output mux to NCH channels, configurable sample width, buffering, two output formats, and overflow accounting.
- Sits between the CIC decimator outputs and the host read interface, entirely in the adc_clk domain.

Parameters:
NCH, 4, number of input channels (1..8)
IN_BITS, 18, signed sample width per I/Q (17..24)
DEPTH, 16, FIFO depth in samples (power of 2, >= 4)

Ports:
adc_clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
in_strobe  in  NCH  per-channel sample-valid, one-cycle pulse
in_i  in  NCH*IN_BITS  channel c I sample at [c*IN_BITS +: IN_BITS], signed
in_q  in  NCH*IN_BITS  channel c Q sample, same packing
ch_en  in  NCH  channel enable
fmt  in  1  0 = 3-word format, 1 = 2-word format
rd_pulse  in  1  host read strobe; advances one word
rd_dout  out  16  current output word
rd_valid  out  1  FIFO non-empty, rd_dout meaningful
rd_ch  out  3  channel tag of head sample
rd_first  out  1  rd_dout is word 0 of a sample
level  out  clog2(DEPTH)+1  FIFO occupancy in samples
ovfl_cnt  out  16  dropped-sample count, saturating
clr_ovfl  in  1  synchronous clear of ovfl_cnt

Behaviour:
- Reset (async, reset_n=0): all pending flags 0, FIFO empty, word index 0, RR pointer 0, ovfl_cnt 0. Outputs: rd_dout=0, rd_valid=0, rd_ch=0, rd_first=1, level=0.
- Capture: per channel, one-deep holding register plus pending flag.
  - in_strobe[c] & ch_en[c] & !pending[c]: latch I/Q, set pending.
  - in_strobe[c] & ch_en[c] & pending[c]: new sample dropped, held sample kept, ovfl_cnt+1.
  - ch_en[c]=0: strobes ignored; pending[c] cleared on the next edge.
  - Multiple channels colliding in the same cycle: each is counted once.
- Arbiter: each cycle, if FIFO not full, write the first pending channel at or after the RR pointer; clear its pending flag; RR pointer becomes winner+1 mod NCH.
  - FIFO full: no write; pending is held; overflow then arises only via the capture rule.
  - A strobe and a write of the same channel in the same cycle: the write takes the old held value, the new value is latched, pending stays 1, no drop.
- Latency: strobe at edge N gives pending at N+1; earliest FIFO write at N+1; level and rd_valid update at N+2.
- FIFO entry: {ch[2:0], I, Q}. Simultaneous write and pop leave level unchanged. Level is never > DEPTH.
- Readout word index w, 0..L-1, where L = 3 if fmt=0 and L = 2 if fmt=1.
  - fmt is sampled when w=0 and held for the rest of that sample.
  - fmt=0: w0 = I[15:0]; w1 = Q[15:0]; w2 = {sext8(I[IN_BITS-1:16]), sext8(Q[IN_BITS-1:16])}.
  - fmt=1: w0 = I[IN_BITS-1 -:16]; w1 = Q[IN_BITS-1 -:16]. Truncation only, no rounding.
  - rd_dout and rd_ch are combinational from the FIFO head and w.
  - rd_first = (w==0).
- Handshake:
  - rd_pulse & rd_valid: w increments; at w=L-1, pop and set w to 0.
  - rd_pulse with rd_valid=0: ignored, w unchanged.
  - Empty FIFO: rd_dout=0.
- ovfl_cnt saturates at 16'hFFFF. If clr_ovfl and a drop coincide, the result is 1.
- reset_n deassertion mid-stream: FIFO contents are lost and no partial sample is presented afterwards.

Test Plan:
- Single channel, NCH=4, IN_BITS=18, fmt=0, ch1 strobe with I=18'h2ABCD, Q=18'h1_0001 -> words 16'hABCD, 16'h0001, 16'hFE01; rd_ch=1; rd_first=1 only on the first word; level returns to 0 after the third rd_pulse.
- Same-cycle strobes on ch0..ch3, FIFO empty, no reads -> FIFO order 0,1,2,3; level=4 by 5 cycles after the strobe; ovfl_cnt=0.
- Continuous ch0 strobes every cycle, no reads, DEPTH=16 -> level saturates at 16; pending held; each further strobe increments ovfl_cnt by 1; clr_ovfl returns it to 0.
- fmt=1, I=18'h2ABCD, Q=18'h1FFFF -> words 16'hAAF3, 16'h7FFF. Toggling fmt after the first word has no effect until the next sample.
- rd_pulse on an empty FIFO for 5 cycles, then one sample written -> w stays 0; first word read is correct; no spurious pop.
- Reset asserted after word 1 of a 3-word sample -> all outputs at reset values immediately; after release, a new sample starts at word 0.
